regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between NREQ writeback sources: ALU/execute, load unit, and CSR/multicycle.
- Arbitrates round-robin, registers the winning write onto the regfile write port, and drives the port one cycle after the grant.
- Keeps a per-register pending-write scoreboard. Decode uses it to stall on RAW hazards against results not yet presented to the regfile.

Parameters:
NREQ, 3, number of writeback requesters (2..4); index 0 = execute, 1 = load, 2 = CSR/mul.
CNT_W, 2, width of the per-register outstanding-producer counter.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  requester i has a result this cycle
req_ready  out  NREQ  requester i granted this cycle (handshake completes on valid&ready)
req_reg  in  5*NREQ  destination register, slice i = [5i+4:5i]
req_data  in  32*NREQ  result data, slice i = [32i+31:32i]
wreg  out  5  regfile write register
wdata  out  32  regfile write data
wen  out  1  regfile write enable
sb_set  in  1  decode issues an instruction writing sb_reg
sb_reg  in  5  destination of issuing instruction
sb_full  out  1  counter for sb_reg saturated; decode must stall (combinational)
rs1  in  5  decode source 1 lookup
rs2  in  5  decode source 2 lookup
busy1  out  1  rs1 has an outstanding producer (combinational from state)
busy2  out  1  rs2 has an outstanding producer
flush  in  1  pipeline flush; clears scoreboard

Behaviour:
- Reset (async, reset_n=0):
  - wen=0, wreg=0, wdata=0.
  - All counters = 0.
  - RR pointer = 0.
  - req_ready=0 while in reset.
- Arbitration (combinational):
  - Search requesters starting at the pointer, wrapping modulo NREQ. The first with req_valid=1 gets req_ready=1; all others 0.
  - No valid requester: no grant.
  - Ready depends on valid. A requester must not depend on ready to assert valid.
- Pointer update: on a grant to requester g, the pointer becomes (g+1) mod NREQ at the clock edge. No grant: the pointer holds.
- Output stage (registered, always drains; the regfile never stalls):
  - Grant at cycle N: wen=1, wreg=req_reg[g], wdata=req_data[g] during cycle N+1.
  - No grant at N: wen=0 at N+1; wreg/wdata hold their old values.
  - req_reg=0 granted: the handshake completes, wen stays 0, and no counter changes.
- Scoreboard:
  - One CNT_W counter per register x1..x31; x0 is always 0, never busy, never full.
  - Increment on sb_set & ~sb_full & sb_reg!=0.
  - Decrement on a grant to register r (r!=0), at the same edge that loads the output stage. During the wen cycle, busy is already 0 and the regfile passthrough supplies the data.
  - Increment and decrement of the same register in the same cycle: the counter is unchanged.
  - Decrement at 0: stays 0 (protocol error). Non-synthesis $display warning.
  - sb_full = sb_set & sb_reg!=0 & count[sb_reg]==all-ones & no same-cycle grant to sb_reg.
  - busyK = count[rsK]!=0.
- Flush:
  - All counters go to 0 at the edge, overriding same-cycle set/decrement.
  - Arbitration and the output stage are unaffected. Results already presented are still written.
- Reset mid-operation: an in-flight output write is dropped, and wen drops asynchronously.
- Non-synthesis: $display each grant (requester index, register, data).

Test Plan:
1. Single requester: reset; sb_set x5; next cycle req_valid[1]=1, reg=5, data=0xDEADBEEF. Expect ready[1]=1; busy1(rs1=5)=1 before the grant and 0 after the edge; next cycle wen=1, wreg=5, wdata=0xDEADBEEF.
2. Round-robin fairness: all three valid continuously with regs 1/2/3. Expect grants 0,1,2,0,1,2...; wen=1 every cycle with wreg 1,2,3,1... one cycle behind.
3. Saturation (CNT_W=2): four sb_set of x7 with no grants. Counts reach 1,2,3; the fourth shows sb_full=1 and the count stays 3. The same set with a concurrent grant to x7 shows sb_full=0 and the count stays 3.
4. x0 handling: sb_set x0, then a granted request to x0. Expect busy=0 for x0, sb_full=0, ready=1, and wen stays 0.
5. Flush: counts x3=2, x4=1; assert flush together with a grant to x3 and sb_set x4. Next cycle all busy=0, and wen=1 for x3 still occurs.
6. Async reset mid-stream: with wen=1, pull reset_n low between edges. wen goes 0 immediately, counters clear, and the pointer restarts at 0 (first grant goes to requester 0 when all are valid).

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// regfile_wb_arbiter: round-robin writeback arbiter with pending-write scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int NREQ  = 3,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [5*NREQ-1:0] req_reg,
  input  logic [32*NREQ-1:0] req_data,
  output logic [4:0]        wreg,
  output logic [31:0]       wdata,
  output logic              wen,
  input  logic              sb_set,
  input  logic [4:0]        sb_reg,
  output logic              sb_full,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic              busy1,
  output logic              busy2,
  input  logic              flush
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0]               ptr_q, ptr_d;
  logic                        wen_q;
  logic [4:0]                  wreg_q;
  logic [31:0]                 wdata_q;
  logic [31:0][CNT_W-1:0]      cnt_q, cnt_d;

  logic                        w_gnt_vld;
  logic [PW-1:0]               w_gnt_idx;
  logic [4:0]                  w_gnt_reg;
  logic [31:0]                 w_gnt_data;
  logic                        w_inc;
  logic                        w_dec;
  logic                        w_full;

  // Rotating priority search starting at the pointer.
  always_comb begin
    int idx;
    idx        = 0;
    w_gnt_vld  = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_reg  = '0;
    w_gnt_data = '0;
    req_ready  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!w_gnt_vld && req_valid[idx]) begin
        w_gnt_vld  = 1'b1;
        w_gnt_idx  = PW'(idx);
        w_gnt_reg  = req_reg[5*idx +: 5];
        w_gnt_data = req_data[32*idx +: 32];
      end
    end
    if (!reset_n) begin
      w_gnt_vld = 1'b0;
    end
    if (w_gnt_vld) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (w_gnt_vld) begin
      ptr_d = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  // A same-cycle retirement of sb_reg frees a slot, so saturation is not reported.
  assign w_dec  = w_gnt_vld && (w_gnt_reg != 5'd0);
  assign w_full = sb_set && (sb_reg != 5'd0) && (cnt_q[sb_reg] == '1) &&
                  !(w_dec && (w_gnt_reg == sb_reg));
  assign w_inc  = sb_set && (sb_reg != 5'd0) && !w_full;

  always_comb begin
    logic inc_r;
    logic dec_r;
    cnt_d = cnt_q;
    inc_r = 1'b0;
    dec_r = 1'b0;
    for (int r = 1; r < 32; r++) begin
      inc_r = w_inc && (sb_reg == 5'(r));
      dec_r = w_dec && (w_gnt_reg == 5'(r));
      if (flush) begin
        cnt_d[r] = '0;
      end else if (inc_r && !dec_r) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec_r && !inc_r && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      wen_q   <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      wen_q <= w_dec;
      if (w_dec) begin
        wreg_q  <= w_gnt_reg;
        wdata_q <= w_gnt_data;
      end
    end
  end

  assign wen     = wen_q;
  assign wreg    = wreg_q;
  assign wdata   = wdata_q;
  assign sb_full = w_full;
  assign busy1   = (cnt_q[rs1] != '0);
  assign busy2   = (cnt_q[rs2] != '0);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n) begin
      if (w_gnt_vld) begin
        $display("regfile_wb_arbiter: grant req %0d reg x%0d data %h",
                 w_gnt_idx, w_gnt_reg, w_gnt_data);
      end
      if (w_dec && !flush && !(w_inc && (sb_reg == w_gnt_reg)) &&
          (cnt_q[w_gnt_reg] == '0)) begin
        $display("regfile_wb_arbiter: warning, writeback to x%0d with no outstanding producer",
                 w_gnt_reg);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [5*NREQ-1:0] req_reg;
  logic [32*NREQ-1:0] req_data;
  logic [4:0]        wreg;
  logic [31:0]       wdata;
  logic              wen;
  logic              sb_set;
  logic [4:0]        sb_reg;
  logic              sb_full;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic              busy1;
  logic              busy2;
  logic              flush;

  int n_cmp;
  int n_err;

  regfile_wb_arbiter #(.NREQ(NREQ), .CNT_W(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_reg   (req_reg),
    .req_data  (req_data),
    .wreg      (wreg),
    .wdata     (wdata),
    .wen       (wen),
    .sb_set    (sb_set),
    .sb_reg    (sb_reg),
    .sb_full   (sb_full),
    .rs1       (rs1),
    .rs2       (rs2),
    .busy1     (busy1),
    .busy2     (busy2),
    .flush     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
    req_reg[5*i +: 5]   = r;
    req_data[32*i +: 32] = d;
  endtask

  initial begin
    int exp_g;
    n_cmp     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    req_valid = '1;
    req_reg   = '0;
    req_data  = '0;
    sb_set    = 1'b0;
    sb_reg    = '0;
    rs1       = '0;
    rs2       = '0;
    flush     = 1'b0;

    // Reset state
    tick();
    tick();
    check_eq("rst_wen",   32'(wen),       32'd0);
    check_eq("rst_wreg",  32'(wreg),      32'd0);
    check_eq("rst_wdata", wdata,          32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    reset_n   = 1'b1;
    tick();

    // 1: single requester
    sb_set = 1'b1; sb_reg = 5'd5; rs1 = 5'd5;
    tick();
    sb_set = 1'b0;
    check_eq("t1_busy_pre", 32'(busy1), 32'd1);
    req_valid = 3'b010;
    set_req(1, 5'd5, 32'hDEADBEEF);
    #1;
    check_eq("t1_ready", 32'(req_ready), 32'b010);
    tick();
    req_valid = '0;
    check_eq("t1_busy_post", 32'(busy1), 32'd0);
    check_eq("t1_wen",   32'(wen),  32'd1);
    check_eq("t1_wreg",  32'(wreg), 32'd5);
    check_eq("t1_wdata", wdata,     32'hDEADBEEF);
    tick();
    check_eq("t1_idle_wen",  32'(wen),  32'd0);
    check_eq("t1_idle_wreg", 32'(wreg), 32'd5);

    // 2: round-robin with all valid; pointer sits at 2 after the grant to 1
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'h100 + 32'(i));
    req_valid = 3'b111;
    exp_g = 2;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_eq("t2_ready", 32'(req_ready), 32'(1 << exp_g));
      tick();
      check_eq("t2_wen",   32'(wen),  32'd1);
      check_eq("t2_wreg",  32'(wreg), 32'(exp_g + 1));
      check_eq("t2_wdata", wdata,     32'h100 + 32'(exp_g));
      exp_g = (exp_g + 1) % NREQ;
    end
    req_valid = '0;
    tick();

    // 3: saturation of x7 (pointer at 2)
    sb_set = 1'b1; sb_reg = 5'd7;
    for (int c = 1; c <= 3; c++) begin
      #1;
      check_eq("t3_full_fill", 32'(sb_full), 32'd0);
      tick();
      check_eq("t3_cnt", 32'(dut.cnt_q[7]), 32'(c));
    end
    #1;
    check_eq("t3_full_sat", 32'(sb_full), 32'd1);
    tick();
    check_eq("t3_cnt_sat", 32'(dut.cnt_q[7]), 32'd3);
    req_valid = 3'b001;
    set_req(0, 5'd7, 32'h77);
    #1;
    check_eq("t3_full_gnt",  32'(sb_full),   32'd0);
    check_eq("t3_ready_gnt", 32'(req_ready), 32'b001);
    tick();
    sb_set = 1'b0; req_valid = '0;
    check_eq("t3_cnt_gnt", 32'(dut.cnt_q[7]), 32'd3);
    check_eq("t3_wreg",    32'(wreg),         32'd7);

    // 4: x0 never tracked or written (pointer at 1)
    sb_set = 1'b1; sb_reg = 5'd0; rs2 = 5'd0;
    #1;
    check_eq("t4_full", 32'(sb_full), 32'd0);
    tick();
    sb_set = 1'b0;
    check_eq("t4_busy", 32'(busy2), 32'd0);
    req_valid = 3'b010;
    set_req(1, 5'd0, 32'h55);
    #1;
    check_eq("t4_ready", 32'(req_ready), 32'b010);
    tick();
    req_valid = '0;
    check_eq("t4_wen", 32'(wen), 32'd0);

    // 5: flush with concurrent grant and set (pointer at 2)
    sb_set = 1'b1; sb_reg = 5'd3; tick();
    tick();
    sb_reg = 5'd4; tick();
    sb_set = 1'b0;
    rs1 = 5'd3; rs2 = 5'd4;
    #1;
    check_eq("t5_busy3", 32'(busy1), 32'd1);
    check_eq("t5_busy4", 32'(busy2), 32'd1);
    flush = 1'b1; sb_set = 1'b1; sb_reg = 5'd4;
    req_valid = 3'b001;
    set_req(0, 5'd3, 32'h333);
    #1;
    check_eq("t5_ready", 32'(req_ready), 32'b001);
    tick();
    flush = 1'b0; sb_set = 1'b0; req_valid = '0;
    check_eq("t5_busy3_f", 32'(busy1), 32'd0);
    check_eq("t5_busy4_f", 32'(busy2), 32'd0);
    check_eq("t5_wen",     32'(wen),   32'd1);
    check_eq("t5_wreg",    32'(wreg),  32'd3);
    check_eq("t5_wdata",   wdata,      32'h333);
    rs1 = 5'd7;
    #1;
    check_eq("t5_busy7_f", 32'(busy1), 32'd0);

    // 6: async reset mid-stream (pointer at 1)
    req_valid = 3'b010;
    set_req(1, 5'd9, 32'h99);
    sb_set = 1'b1; sb_reg = 5'd10; rs1 = 5'd10;
    tick();
    sb_set = 1'b0;
    check_eq("t6_wen",  32'(wen),   32'd1);
    check_eq("t6_busy", 32'(busy1), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_wen",   32'(wen),       32'd0);
    check_eq("t6_rst_wreg",  32'(wreg),      32'd0);
    check_eq("t6_rst_busy",  32'(busy1),     32'd0);
    check_eq("t6_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(11 + i), 32'hA0 + 32'(i));
    req_valid = 3'b111;
    #1;
    check_eq("t6_ready0", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    check_eq("t6_wreg0", 32'(wreg), 32'd11);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
